// File: rtl/rshift_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : rshift_seq_if
// Purpose  : Operand/result bundle for the sequential right shifter. Keeps the
//            init/portA/portB/out/DONE style shared with the left shifter.
// Signals  : init  - start request (level, sampled while idle)
//            arith - 0 logical / 1 arithmetic, sampled with init
//            portA - operand, portB - unsigned shift amount
//            out   - registered result, DONE - result valid
//            busy  - operation in progress or result being held
// Modports : master - requester side, slave - shifter side
// Revision : 1.0 - initial release
// ============================================================================
interface rshift_seq_if #(
  parameter int WIDTH = 3
);
  logic             init;
  logic             arith;
  logic [WIDTH-1:0] portA;
  logic [WIDTH-1:0] portB;
  logic [WIDTH-1:0] out;
  logic             DONE;
  logic             busy;

  modport master (
    output init,
    output arith,
    output portA,
    output portB,
    input  out,
    input  DONE,
    input  busy
  );

  modport slave (
    input  init,
    input  arith,
    input  portA,
    input  portB,
    output out,
    output DONE,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/rshift_seq.sv
`default_nettype none
// ============================================================================
// Module   : rshift_seq
// Purpose  : Sequential right shifter. Shifts portA right by portB positions,
//            one position per clock, in logical (zero-fill) or arithmetic
//            (sign-fill) mode, under an init/DONE handshake.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - rshift_seq_if.slave (init, arith, portA, portB in;
//                    out, DONE, busy out)
// Timing   : DONE rises min(portB, WIDTH) + 1 edges after the load edge and
//            holds until init is seen low; out keeps the last result.
// Revision : 1.0 - initial release
// ============================================================================
module rshift_seq #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  rshift_seq_if.slave   bus
);

  // Counter must hold values 0..WIDTH inclusive.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] C_CNT_MAX   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] C_AMT_LIMIT = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             arith_q, arith_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             done_q,  done_d;

  logic             fill_bit;
  logic [CNT_W-1:0] load_cnt;

  // Sign fill only in arithmetic mode; the MSB of the working register is
  // the sign because every previous shift already replicated it.
  assign fill_bit = arith_q & data_q[WIDTH-1];

  // Clamp the shift amount so oversize shifts take at most WIDTH cycles;
  // WIDTH shifts already yield all-fill, so further shifts change nothing.
  always_comb begin
    load_cnt = C_CNT_MAX;
    if (bus.portB <= C_AMT_LIMIT) begin
      load_cnt = bus.portB[CNT_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      arith_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      arith_q <= arith_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    arith_d = arith_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        // Operands are captured here only; later changes on the bus are
        // ignored until the next operation.
        if (bus.init) begin
          data_d  = bus.portA;
          arith_d = bus.arith;
          cnt_d   = load_cnt;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {fill_bit, data_q[WIDTH-1:1]};
          cnt_d  = cnt_q - C_CNT_ONE;
        end else begin
          out_d   = data_q;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        // A held init never restarts; the requester must drop it first.
        if (!bus.init) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.DONE = done_q;
  assign bus.busy = (state_q == S_SHIFT) || (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: doc/rshift_seq.md
Name: rshift_seq

Overview:
- Sequential right-shift unit; the companion direction to the team's combinational left shifter.
- Shifts portA right by portB positions, one bit position per clock, under an init/DONE handshake.
- Supports logical (zero-fill) and arithmetic (sign-fill) modes.
- Sits beside the left shifter in the lab ALU datapath and shares its init/portA/portB/out/DONE interface style.

Parameters:
- WIDTH, 3, data width of portA, portB and out; WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init  input  1  start request, level-sensitive, sampled in IDLE.
- arith  input  1  0 = logical shift, 1 = arithmetic shift; sampled with init.
- portA  input  WIDTH  operand to shift.
- portB  input  WIDTH  shift amount, unsigned.
- out  output  WIDTH  result, registered.
- DONE  output  1  result valid, registered.
- busy  output  1  high in SHIFT and FINISH states.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - state=IDLE; out=0; DONE=0; busy=0; internal shift register and counter cleared.
  - Any operation in progress is abandoned; nothing resumes after reset is released.
- States: IDLE, SHIFT, FINISH.
- IDLE, init=1 at an edge:
  - Load data register with portA and mode bit with arith.
  - Load cnt = min(portB, WIDTH); clamping means oversize shifts never take more than WIDTH cycles.
  - Go to SHIFT. busy=1 from this edge; out unchanged.
- IDLE, init=0: remain in IDLE.
- SHIFT, cnt>0 at an edge:
  - Data register shifts right 1 bit.
  - Fill bit is 0 (logical) or the data register's MSB (arithmetic).
  - cnt decrements.
- SHIFT, cnt==0 at an edge: out <= data register; DONE <= 1; go to FINISH.
- FINISH:
  - out and DONE hold.
  - When init=0 at an edge: DONE <= 0, busy <= 0, go to IDLE. out keeps its last result.
  - While init stays 1, no restart occurs. A new operation requires init low for at least one edge, then high again.
- Latency: DONE rises at edge L = min(portB, WIDTH) + 1 after the load edge.
  - portB=0 gives L=1.
- Operand stability: portA, portB and arith changes after the load edge have no effect on the current operation.
- Width rules:
  - portB >= WIDTH gives 0 (logical), or all bits equal to portA's MSB (arithmetic).
  - No overflow or carry output.
- busy=1 exactly in SHIFT and FINISH; DONE=1 only in FINISH.

Test Plan:
- WIDTH=3, reset released, portA=5, portB=1, arith=0, init=1 -> load edge, shift edge, then DONE=1 at edge 2 with out=2; init=0 -> DONE=0 next edge, out stays 2.
- portA=5, portB=1, arith=1 -> out=6 (110), DONE at edge 2; portA=3, portB=2, arith=1 -> out=0.
- portA=5, portB=0, either mode -> out=5, DONE=1 at edge 1 after load.
- portA=5, portB=7: arith=0 -> out=0; arith=1 -> out=7. Both assert DONE at edge 4, confirming the clamp to WIDTH.
- Start portA=4, portB=3, arith=0; assert rst_n=0 between edges 1 and 2 -> out, DONE and busy go to 0 immediately. After release with init=0, the block stays IDLE with out=0.
- Hold init=1 for 10 cycles after DONE -> DONE stays 1, out stable, no reload even if portA changes. Drop init for one edge, raise with new operands -> new operation completes correctly.
